// File: rtl/ee457_dmem_resp_pkg.sv
// Shared constants and types for the ee457 data-memory responder.
package ee457_dmem_resp_pkg;

  // Word and byte-offset geometry; also used by the instruction-side responder.
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFS_W  = 2;

  // Bit positions of the sticky error flags inside the error register.
  localparam int unsigned ERR_W        = 3;
  localparam int unsigned ERR_ALIGN    = 0;
  localparam int unsigned ERR_RANGE    = 1;
  localparam int unsigned ERR_CONFLICT = 2;

  typedef logic [WORD_W-1:0] word_t;

  // Per-cycle decode of one CPU access.
  typedef struct packed {
    logic lo_ok;     // byte offset is zero
    logic hi_ok;     // address lies inside the array
    logic load_ok;   // accepted load
    logic store_ok;  // accepted store (no simultaneous load)
    logic conflict;  // load and store requested together
  } acc_cls_t;

endpackage : ee457_dmem_resp_pkg

// File: rtl/ee457_dmem_resp_wbuf.sv
// Posted-write FIFO with a youngest-entry associative lookup for store-to-load bypass.
module ee457_dmem_resp_wbuf
  import ee457_dmem_resp_pkg::*;
#(
  parameter int unsigned AW   = 10,
  parameter int unsigned WB_D = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [AW-1:0]          i_push_idx,
  input  word_t                  i_push_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(WB_D):0]  o_count,
  output logic [AW-1:0]          o_head_idx,
  output word_t                  o_head_data,
  input  logic [AW-1:0]          i_lk_idx,
  output logic                   o_lk_hit,
  output word_t                  o_lk_data
);

  localparam int unsigned PW = $clog2(WB_D);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] r_idx  [WB_D];
  word_t         r_data [WB_D];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_pos;
  logic          w_hit;
  word_t         w_data;

  // Pointers wrap naturally because the depth is a power of two; the count is explicit occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_idx[r_wptr]  <= i_push_idx;
      r_data[r_wptr] <= i_push_data;
    end
  end

  // Scan oldest to youngest so the last live match found is the youngest one.
  always_comb begin
    w_hit  = 1'b0;
    w_data = '0;
    w_pos  = '0;
    for (int unsigned k = 0; k < WB_D; k++) begin
      w_pos = r_rptr + PW'(k);
      if ((CW'(k) < r_count) && (r_idx[w_pos] == i_lk_idx)) begin
        w_hit  = 1'b1;
        w_data = r_data[w_pos];
      end
    end
  end

  assign o_lk_hit    = w_hit;
  assign o_lk_data   = w_data;
  assign o_full      = (r_count == CW'(WB_D));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_idx  = r_idx[r_rptr];
  assign o_head_data = r_data[r_rptr];

endmodule : ee457_dmem_resp_wbuf

// File: rtl/ee457_dmem_resp.sv
// Data-memory responder: combinational loads with write-buffer bypass, posted stores,
// sticky error flags and saturating access counters.
module ee457_dmem_resp
  import ee457_dmem_resp_pkg::*;
#(
  parameter int unsigned AW    = 10,
  parameter int unsigned WB_D  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      dmem_addr,
  input  logic [WORD_W-1:0]      dmem_wdata,
  input  logic                   dmemread,
  input  logic                   dmemwrite,
  output logic [WORD_W-1:0]      dmem_rdata,
  input  logic                   flush,
  output logic                   wb_empty,
  output logic [$clog2(WB_D):0]  wb_count,
  output logic                   err_align,
  output logic                   err_range,
  output logic                   err_conflict,
  output logic [CNT_W-1:0]       rd_count,
  output logic [CNT_W-1:0]       wr_count,
  output logic [CNT_W-1:0]       forced_drains
);

  localparam int unsigned DEPTH = 2 ** AW;

  acc_cls_t         w_cls;
  logic [AW-1:0]    w_idx;
  logic             w_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_drain;
  logic             w_forced;
  logic [AW-1:0]    w_head_idx;
  word_t            w_head_data;
  logic             w_lk_hit;
  word_t            w_lk_data;
  word_t            r_mem [DEPTH];
  logic [ERR_W-1:0] r_err;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_fd_cnt;

  // Classify the current access from its address and request strobes.
  always_comb begin
    w_cls          = '0;
    w_cls.lo_ok    = (dmem_addr[OFS_W-1:0] == '0);
    w_cls.hi_ok    = (dmem_addr[WORD_W-1:AW+OFS_W] == '0);
    w_cls.load_ok  = dmemread && w_cls.lo_ok && w_cls.hi_ok;
    w_cls.store_ok = dmemwrite && !dmemread && w_cls.lo_ok && w_cls.hi_ok;
    w_cls.conflict = dmemread && dmemwrite;
  end

  assign w_valid = w_cls.lo_ok && w_cls.hi_ok;
  assign w_idx   = dmem_addr[AW+OFS_W-1:OFS_W];

  // Drain whenever the array port is free, when flushing, or when a full buffer must make room.
  assign w_drain  = !w_empty && (flush || !dmemread || w_full);
  assign w_forced = w_full && dmemread;

  ee457_dmem_resp_wbuf #(
    .AW   (AW),
    .WB_D (WB_D)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_cls.store_ok),
    .i_push_idx  (w_idx),
    .i_push_data (dmem_wdata),
    .i_pop       (w_drain),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (wb_count),
    .o_head_idx  (w_head_idx),
    .o_head_data (w_head_data),
    .i_lk_idx    (w_idx),
    .o_lk_hit    (w_lk_hit),
    .o_lk_data   (w_lk_data)
  );

  // Word array written only by drains; its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_drain) r_mem[w_head_idx] <= w_head_data;
  end

  // Load data: youngest buffered store wins over the array; zero for idle, invalid or reset.
  always_comb begin
    dmem_rdata = '0;
    if (rst && w_cls.load_ok && w_valid) begin
      dmem_rdata = w_lk_hit ? w_lk_data : r_mem[w_idx];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      if ((dmemread || dmemwrite) && !w_cls.lo_ok) r_err[ERR_ALIGN]    <= 1'b1;
      if ((dmemread || dmemwrite) && !w_cls.hi_ok) r_err[ERR_RANGE]    <= 1'b1;
      if (w_cls.conflict)                          r_err[ERR_CONFLICT] <= 1'b1;
    end
  end

  // Saturating access counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_fd_cnt <= '0;
    end else begin
      if (w_cls.load_ok && (r_rd_cnt != '1))  r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_cls.store_ok && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      if (w_forced && (r_fd_cnt != '1))       r_fd_cnt <= r_fd_cnt + CNT_W'(1);
    end
  end

  assign wb_empty      = w_empty;
  assign err_align     = r_err[ERR_ALIGN];
  assign err_range     = r_err[ERR_RANGE];
  assign err_conflict  = r_err[ERR_CONFLICT];
  assign rd_count      = r_rd_cnt;
  assign wr_count      = r_wr_cnt;
  assign forced_drains = r_fd_cnt;

endmodule : ee457_dmem_resp

// File: tb/tb_ee457_dmem_resp.sv
// Bench for ee457_dmem_resp: directed vector table, hand-written reset/flush sequences,
// and randomized traffic against a queue-based reference model.
module tb_ee457_dmem_resp;

  localparam int unsigned AW   = 10;
  localparam int unsigned WB_D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, dmem_rdata_s;
  logic        dmemread, dmemwrite, flush;
  logic        wb_empty, wb_empty_s;
  logic [2:0]  wb_count, wb_count_s;
  logic        err_align, err_range, err_conflict;
  logic        err_align_s, err_range_s, err_conflict_s;
  logic [15:0] rd_count, wr_count, forced_drains;
  logic [1:0]  rd_count_s, wr_count_s, forced_drains_s;

  always #5 clk = ~clk;

  ee457_dmem_resp #(.AW(AW), .WB_D(WB_D), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmemread(dmemread), .dmemwrite(dmemwrite), .dmem_rdata(dmem_rdata), .flush(flush),
    .wb_empty(wb_empty), .wb_count(wb_count), .err_align(err_align), .err_range(err_range),
    .err_conflict(err_conflict), .rd_count(rd_count), .wr_count(wr_count),
    .forced_drains(forced_drains));

  // Narrow-counter copy so saturation is reached quickly.
  ee457_dmem_resp #(.AW(AW), .WB_D(WB_D), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmemread(dmemread), .dmemwrite(dmemwrite), .dmem_rdata(dmem_rdata_s), .flush(flush),
    .wb_empty(wb_empty_s), .wb_count(wb_count_s), .err_align(err_align_s),
    .err_range(err_range_s), .err_conflict(err_conflict_s), .rd_count(rd_count_s),
    .wr_count(wr_count_s), .forced_drains(forced_drains_s));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending stores in a queue, drained words in an associative array.
  typedef struct { int unsigned idx; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] marr[int unsigned];
  int unsigned m_rd, m_wr, m_fd;
  bit          m_ea, m_er, m_ec;

  typedef struct {
    bit rd; bit wr; bit fl;
    logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_rdata; int unsigned exp_cnt;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_valid(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  function automatic int unsigned sat3(input int unsigned x);
    return (x > 3) ? 3 : x;
  endfunction

  // Expected load data; known=0 when the word was never written since power-up.
  task automatic model_read(input bit rd, input logic [31:0] a, output bit known,
                            output logic [31:0] v);
    int unsigned ix;
    known = 1'b1;
    v     = '0;
    if (rd && m_valid(a)) begin
      ix = int'(a[AW+1:2]);
      known = 1'b0;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].idx == ix) begin known = 1'b1; v = mq[i].data; end
      if (!known && marr.exists(ix)) begin known = 1'b1; v = marr[ix]; end
    end
  endtask

  task automatic model_edge(input bit rd, input bit wr, input bit fl,
                            input logic [31:0] a, input logic [31:0] wd);
    ent_t e;
    bit   ok;
    ok = m_valid(a);
    if ((rd || wr) && a[1:0] != 2'b00) m_ea = 1'b1;
    if ((rd || wr) && a[31:AW+2] != '0) m_er = 1'b1;
    if (rd && wr) m_ec = 1'b1;
    if (rd && ok) m_rd++;
    if (rd && mq.size() == WB_D) m_fd++;
    if (mq.size() > 0 && (fl || !rd || mq.size() == WB_D)) begin
      e = mq.pop_front();
      marr[e.idx] = e.data;
    end
    if (wr && !rd && ok) begin
      e.idx  = int'(a[AW+1:2]);
      e.data = wd;
      mq.push_back(e);
      m_wr++;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd = 0; m_wr = 0; m_fd = 0;
    m_ea = 1'b0; m_er = 1'b0; m_ec = 1'b0;
  endtask

  task automatic check_regs();
    chk("wb_count", 32'(wb_count), 32'(mq.size()));
    chk("wb_empty", 32'(wb_empty), 32'(mq.size() == 0));
    chk("err_flags", {29'd0, err_conflict, err_range, err_align}, {29'd0, m_ec, m_er, m_ea});
    chk("rd_count", 32'(rd_count), m_rd);
    chk("wr_count", 32'(wr_count), m_wr);
    chk("forced_drains", 32'(forced_drains), m_fd);
    chk("rd_count_sat", 32'(rd_count_s), sat3(m_rd));
    chk("wr_count_sat", 32'(wr_count_s), sat3(m_wr));
  endtask

  // One clock of traffic: inputs driven mid-cycle, load data sampled before the edge.
  task automatic step(input bit rd, input bit wr, input bit fl, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] seen);
    bit          known;
    logic [31:0] exp;
    dmemread = rd; dmemwrite = wr; flush = fl; dmem_addr = a; dmem_wdata = wd;
    #1;
    seen = dmem_rdata;
    model_read(rd, a, known, exp);
    if (known) chk("rdata", dmem_rdata, exp);
    @(posedge clk);
    model_edge(rd, wr, fl, a, wd);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    dmemread = 1'b1; dmemwrite = 1'b0; flush = 1'b0; dmem_addr = 32'h10;
    rst = 1'b0;
    #1;
    chk("rdata_in_reset", dmem_rdata, 32'h0);
    model_reset();
    check_regs();
    @(negedge clk);
    rst = 1'b1;
    dmemread = 1'b0;
    #1;
    check_regs();
  endtask

  logic [31:0] seen;
  logic [31:0] ra;

  initial begin
    tbl[0]  = '{0, 1, 0, 32'h10,   32'hDEADBEEF, 32'h0,        1};
    tbl[1]  = '{1, 0, 0, 32'h10,   32'h0,        32'hDEADBEEF, 1};
    tbl[2]  = '{0, 0, 0, 32'h0,    32'h0,        32'h0,        0};
    tbl[3]  = '{1, 0, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0};
    tbl[4]  = '{0, 1, 0, 32'h20,   32'h1,        32'h0,        1};
    tbl[5]  = '{0, 1, 0, 32'h20,   32'h2,        32'h0,        1};
    tbl[6]  = '{1, 0, 0, 32'h20,   32'h0,        32'h2,        1};
    tbl[7]  = '{0, 0, 0, 32'h0,    32'h0,        32'h0,        0};
    tbl[8]  = '{1, 0, 0, 32'h20,   32'h0,        32'h2,        0};
    tbl[9]  = '{1, 0, 0, 32'h13,   32'h0,        32'h0,        0};
    tbl[10] = '{0, 1, 0, 32'h1000, 32'h5,        32'h0,        0};
    tbl[11] = '{0, 1, 0, 32'h8,    32'h88,       32'h0,        1};
    tbl[12] = '{1, 1, 0, 32'h8,    32'h99,       32'h88,       1};
    tbl[13] = '{0, 1, 0, 32'hC,    32'hCC,       32'h0,        1};

    rst = 1'b0; dmemread = 1'b1; dmemwrite = 1'b0; flush = 1'b0;
    dmem_addr = 32'h10; dmem_wdata = '0;
    model_reset();
    @(negedge clk);
    chk("rdata_in_reset", dmem_rdata, 32'h0);
    check_regs();
    @(negedge clk);
    rst = 1'b1; dmemread = 1'b0;
    #1;
    check_regs();

    // Directed vectors: bypass, youngest match, errors, conflict.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].fl, tbl[i].addr, tbl[i].wdata, seen);
      chk($sformatf("tbl%0d_rdata", i), seen, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_count", i), 32'(wb_count), 32'(tbl[i].exp_cnt));
    end
    chk("tbl_rd_count", 32'(rd_count), 32'd5);
    chk("tbl_wr_count", 32'(wr_count), 32'd5);
    chk("tbl_sat_rd", 32'(rd_count_s), 32'd3);
    chk("tbl_errs", {29'd0, err_conflict, err_range, err_align}, 32'h7);

    // Reset with a store still buffered: it is lost, drained words remain.
    do_reset();
    chk("post_reset_count", 32'(wb_count), 32'd0);
    chk("post_reset_errs", {29'd0, err_conflict, err_range, err_align}, 32'h0);
    step(1, 0, 0, 32'h8, 32'h0, seen);
    chk("array_kept_0x8", seen, 32'h88);

    // Flush drains during a load while the bypass still returns the entry.
    step(0, 1, 0, 32'h30, 32'h3333, seen);
    step(1, 0, 1, 32'h30, 32'h0, seen);
    chk("flush_bypass", seen, 32'h3333);
    chk("flush_count", 32'(wb_count), 32'd0);
    step(1, 0, 0, 32'h30, 32'h0, seen);
    chk("flush_array", seen, 32'h3333);

    // Randomized traffic, with occasional mid-run resets.
    for (int n = 0; n < 600; n++) begin
      int unsigned r, s;
      bit rd, wr, fl;
      if (n % 150 == 149) begin
        do_reset();
      end else begin
        r  = $urandom_range(0, 99);
        rd = (r < 40);
        wr = (r >= 35) && (r < 80);
        fl = ($urandom_range(0, 9) == 0);
        s  = $urandom_range(0, 15);
        ra = {20'd0, 6'd0, 4'(s), 2'b00};
        if (s == 0)  ra[1:0] = 2'($urandom_range(1, 3));
        if (s == 15) ra[31:12] = 20'($urandom_range(1, 255));
        step(rd, wr, fl, ra, $urandom, seen);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_ee457_dmem_resp
